// File: rtl/game_input_pkg.sv
// Shared definitions for the game's button/direction-pad input path.
package game_input_pkg;

  // Channel assignment of the game's physical buttons.
  localparam int CH_START    = 0;
  localparam int CH_RESTART  = 1;
  localparam int CH_MOVE     = 2;
  localparam int CH_PAUSE    = 3;
  localparam int CH_CONTINUE = 4;
  localparam int CH_METHOD   = 5;
  localparam int CH_B1_UP    = 6;
  localparam int CH_B1_DOWN  = 7;
  localparam int CH_B1_LEFT  = 8;
  localparam int CH_B1_RIGHT = 9;
  localparam int CH_B2_UP    = 10;
  localparam int CH_B2_DOWN  = 11;
  localparam int CH_B2_LEFT  = 12;
  localparam int CH_B2_RIGHT = 13;

  // Auto-repeat state of one channel.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a terminal count of n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, polarity fix, debouncer and auto-repeat FSM.
module button_channel
  import game_input_pkg::*;
#(
  parameter int   DEBOUNCE_CYC   = 1000000,
  parameter int   REPEAT_DLY_CYC = 25000000,
  parameter int   REPEAT_PER_CYC = 5000000,
  parameter logic ACTIVE_LOW     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic repeat_en,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam int HW = cnt_width(max_int(REPEAT_DLY_CYC, REPEAT_PER_CYC));
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DLY_CYC - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PER_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          in_q, in_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic [HW-1:0] hold_q, hold_d;
  rpt_state_e    state_q, state_d;

  // Synchronise, correct polarity, and count how long the input has disagreed
  // with the accepted level. The polarity-corrected input is registered so the
  // debounce compare never sits directly on the synchroniser output.
  always_comb begin
    sync1_d   = raw_in;
    sync2_d   = sync1_q;
    in_d      = sync2_q ^ ACTIVE_LOW;
    db_cnt_d  = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (in_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = in_q;
        press_d   = in_q;
        release_d = ~in_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser flops reset to the idle pin level so reset release is silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      in_q      <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      in_q      <= in_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Repeat FSM next state: initial delay, then periodic strobes while held.
  // A release overrides everything, so no repeat can coincide with it.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    repeat_d = 1'b0;
    case (state_q)
      RPT_IDLE: begin
        if (press_d) begin
          state_d = RPT_DELAY;
          hold_d  = '0;
        end
      end
      RPT_DELAY: begin
        if (hold_q == DLY_LAST) begin
          // Saturate here until repeat is enabled.
          if (repeat_en) begin
            repeat_d = 1'b1;
            state_d  = RPT_REPEAT;
            hold_d   = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RPT_REPEAT: begin
        // Period keeps running even while repeat_en masks the strobe.
        if (hold_q == PER_LAST) begin
          repeat_d = repeat_en;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = RPT_IDLE;
        hold_d  = '0;
      end
    endcase
    if (release_d) begin
      state_d  = RPT_IDLE;
      hold_d   = '0;
      repeat_d = 1'b0;
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RPT_IDLE;
      hold_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      repeat_q <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent button_channel per pin.
module button_conditioner
  import game_input_pkg::*;
#(
  parameter int                NUM_CH          = 16,
  parameter int                DEBOUNCE_CYC    = 1000000,
  parameter int                REPEAT_DLY_CYC  = 25000000,
  parameter int                REPEAT_PER_CYC  = 5000000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_repeat,
  output logic              any_press
);

  logic any_press_q, any_press_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
      .REPEAT_PER_CYC(REPEAT_PER_CYC),
      .ACTIVE_LOW    (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (btn_raw[i]),
      .repeat_en(repeat_en[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

  // Combine all press strobes into one "something was pressed" strobe.
  always_comb begin
    any_press_d = |btn_press;
  end

  // Registered, so it trails btn_press by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_press_q <= 1'b0;
    else       any_press_q <= any_press_d;
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// all checked every cycle against a sample-window reference model.
module tb_button_conditioner;

  localparam int         NCH  = 4;
  localparam int         DEB  = 4;
  localparam int         DLY  = 10;
  localparam int         PER  = 3;
  localparam logic [3:0] MASK = 4'b1111;
  localparam int         HL   = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] btn_raw, repeat_en;
  logic [NCH-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic           any_press;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel history of logical samples, one per edge.
  int             cyc;
  logic           hist [NCH][HL];
  logic [NCH-1:0] lvl_m, prs_m, rel_m, rep_m;
  logic           any_m;
  logic [NCH-1:0] held_m, phase_m;
  int             next_slot [NCH];

  button_conditioner #(
    .NUM_CH(NCH), .DEBOUNCE_CYC(DEB), .REPEAT_DLY_CYC(DLY),
    .REPEAT_PER_CYC(PER), .ACTIVE_LOW_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 100;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < HL; k++) hist[c][k] = 1'b0;
      next_slot[c] = 0;
    end
    lvl_m = '0; prs_m = '0; rel_m = '0; rep_m = '0; any_m = 1'b0;
    held_m = '0; phase_m = '0;
  endtask

  // Level flips at edge e when the logical samples taken at edges
  // e-DEB-2 .. e-3 all disagree with the current level.
  task automatic model_step(input logic [NCH-1:0] samp, input logic [NCH-1:0] en);
    logic prev_any;
    logic all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    prev_any = |prs_m;
    prs_m = '0; rel_m = '0; rep_m = '0;
    for (int c = 0; c < NCH; c++) begin
      hist[c][cyc % HL] = samp[c] ^ MASK[c];
      all_diff = 1'b1;
      for (int k = 3; k <= DEB + 2; k++)
        if (hist[c][(cyc - k) % HL] == lvl_m[c]) all_diff = 1'b0;
      if (all_diff) begin
        lvl_m[c] = ~lvl_m[c];
        prs_m[c] = lvl_m[c];
        rel_m[c] = ~lvl_m[c];
      end
      if (rel_m[c]) begin
        held_m[c] = 1'b0;
      end else if (prs_m[c]) begin
        held_m[c] = 1'b1;
        phase_m[c] = 1'b0;
        next_slot[c] = cyc + DLY;
      end else if (held_m[c]) begin
        if (!phase_m[c]) begin
          if (cyc >= next_slot[c] && en[c]) begin
            rep_m[c] = 1'b1;
            phase_m[c] = 1'b1;
            next_slot[c] = cyc + PER;
          end
        end else if (cyc == next_slot[c]) begin
          rep_m[c] = en[c];
          next_slot[c] = cyc + PER;
        end
      end
    end
    any_m = prev_any;
  endtask

  task automatic check_all();
    chk("level",   32'(btn_level),   32'(lvl_m));
    chk("press",   32'(btn_press),   32'(prs_m));
    chk("release", 32'(btn_release), 32'(rel_m));
    chk("repeat",  32'(btn_repeat),  32'(rep_m));
    chk("any",     32'(any_press),   32'(any_m));
  endtask

  task automatic tick();
    logic [NCH-1:0] samp, en;
    samp = btn_raw;
    en   = repeat_en;
    @(posedge clk);
    model_step(samp, en);
    #1;
    check_all();
  endtask

  initial begin
    int press_at, any_at, cnt, rep_cnt, rel_cnt;
    int rep_at [3];
    logic [NCH-1:0] quiet;

    reset = 1'b1; btn_raw = 4'hF; repeat_en = '0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;

    // Idle after reset: nothing at all for 50 cycles.
    quiet = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      quiet |= btn_level | btn_press | btn_release | btn_repeat | {NCH{any_press}};
    end
    chk("idle_quiet", 32'(quiet), 32'd0);

    // Clean press on ch0: edge 0 is the first to sample the new level.
    btn_raw[0] = 1'b0;
    press_at = -1; any_at = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (btn_press[0] && press_at < 0) press_at = k;
      if (any_press && any_at < 0) any_at = k;
    end
    chk("clean_press_lat", 32'(press_at), 32'd6);
    chk("any_press_lat", 32'(any_at), 32'd7);
    chk("clean_level", 32'(btn_level[0]), 32'd1);

    // Bounce on ch1, then settle pressed.
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      btn_raw[1] = b[0];
      for (int i = 0; i < 2; i++) begin
        tick();
        if (btn_press[1]) cnt++;
      end
    end
    chk("bounce_no_early", 32'(cnt), 32'd0);
    btn_raw[1] = 1'b0;
    press_at = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (btn_press[1]) begin
        cnt++;
        if (press_at < 0) press_at = k;
      end
    end
    chk("bounce_press_lat", 32'(press_at), 32'd6);
    chk("bounce_press_once", 32'(cnt), 32'd1);

    // Hold ch2 with repeat enabled.
    repeat_en[2] = 1'b1;
    btn_raw[2] = 1'b0;
    press_at = -1; rep_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (btn_press[2] && press_at < 0) press_at = k;
      if (btn_repeat[2]) begin
        if (rep_cnt < 3) rep_at[rep_cnt] = k;
        rep_cnt++;
      end
    end
    chk("rpt_count_min", 32'(rep_cnt >= 3), 32'd1);
    chk("rpt_first", 32'(rep_at[0] - press_at), 32'd10);
    chk("rpt_second", 32'(rep_at[1] - press_at), 32'd13);
    chk("rpt_third", 32'(rep_at[2] - press_at), 32'd16);
    btn_raw[2] = 1'b1;
    rel_cnt = 0; rep_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rel_cnt > 0 && btn_repeat[2]) rep_cnt++;
      if (btn_release[2]) rel_cnt++;
      if (btn_release[2] && btn_repeat[2]) rep_cnt++;
    end
    chk("release_once", 32'(rel_cnt), 32'd1);
    chk("no_rpt_after_rel", 32'(rep_cnt), 32'd0);

    // Hold ch3 with repeat disabled, then enable mid-hold.
    btn_raw[3] = 1'b0;
    rep_cnt = 0;
    for (int k = 0; k < 46; k++) begin
      tick();
      if (btn_repeat[3]) rep_cnt++;
    end
    chk("rpt_disabled", 32'(rep_cnt), 32'd0);
    repeat_en[3] = 1'b1;
    rep_at[0] = -1; rep_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (btn_repeat[3]) begin
        if (rep_at[0] < 0) rep_at[0] = k;
        rep_cnt++;
      end
    end
    chk("rpt_resume_at", 32'(rep_at[0]), 32'd0);
    chk("rpt_resume_cnt", 32'(rep_cnt), 32'd3);

    // Async reset while ch0 held: level drops at once, press re-fires.
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_level", 32'(btn_level), 32'd0);
    chk("async_rst_strobes", 32'(btn_press | btn_release | btn_repeat), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    press_at = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (btn_press[0] && press_at < 0) press_at = k;
    end
    chk("rst_repress_lat", 32'(press_at), 32'd6);

    // Release everything, then random bouncing with random repeat enables.
    btn_raw = 4'hF;
    for (int i = 0; i < 15; i++) tick();
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) btn_raw[c] = ~btn_raw[c];
        if ($urandom_range(0, 29) == 0) repeat_en[c] = ~repeat_en[c];
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
